// File: rtl/uart_rx_wr_if.sv
// -----------------------------------------------------------------------------
// uart_rx_wr_if
// Write port from the UART receiver to the general-purpose output register.
//   we       : one-cycle write strike
//   wr_data  : byte to write, valid while we=1 and held afterwards
// Modports:
//   master : the receiver, which drives the port
//   slave  : the downstream register, which consumes it
// Handshake: there is no ready. The consumer must capture wr_data on every
// clock edge that ends a cycle with we=1. we is never high for two cycles in a row.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface uart_rx_wr_if;
  logic       we;
  logic [7:0] wr_data;

  modport master (output we, output wr_data);
  modport slave  (input  we, input  wr_data);
endinterface

// File: rtl/uart_rx_wr.sv
// -----------------------------------------------------------------------------
// uart_rx_wr
// UART byte receiver that feeds the write port of the GPO register. It decodes
// 8N1 frames from rxd. With UART_RX_PARITY_EN defined it decodes 8E1 frames
// instead. Each good byte produces a single-cycle we pulse with the byte on
// wr_data.
//
// Configuration macro: UART_RX_PARITY_EN
//   defined   : 8E1 framing, PARITY state present, parity_err active
//   undefined : 8N1 framing, parity_err tied to 0
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 4)
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rxd         in   serial line, idle high, asynchronous to clk
//   wr_if       mst  write port (we, wr_data)
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   parity_err  out  one-cycle pulse on an even-parity mismatch
//   dbg_state   out  current FSM state encoding, for observation only
//                    (0 idle, 1 start, 2 data, 3 parity, 4 stop)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_wr #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rxd,
  uart_rx_wr_if.master  wr_if,
  output logic          frame_err,
  output logic          parity_err,
  output logic [2:0]    dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // START waits half a bit so that every later sample lands at mid-bit.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_we;
  logic [7:0]    r_wr_data;
  logic          r_frame_err;
  logic          r_rx_meta;
  logic          r_rxs;
  logic          w_cnt_zero;
  logic          w_par_bad;

  assign w_cnt_zero = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  // Even parity: data bits plus the parity bit must hold an even number of ones.
  assign w_par_bad  = ^{r_shift, r_par_bit};
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign wr_if.we      = r_we;
  assign wr_if.wr_data = r_wr_data;
  assign frame_err     = r_frame_err;
  assign dbg_state     = r_state;

  // Two-flop synchronizer. It resets to the idle line level so that reset
  // release does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_we         <= 1'b0;
      r_wr_data    <= 8'h00;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // The strobes default low, so each one lasts a single cycle.
      r_we        <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          // A low line also starts a new frame right after a frame error.
          // A held break therefore gives one frame_err per frame time.
          if (!r_rxs) begin
            r_cnt   <= HALF_M1;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_cnt_zero) begin
            if (!r_rxs) begin
              r_cnt   <= FULL_M1;
              r_bit   <= '0;
              r_state <= S_DATA;
            end else begin
              // The line went high again before mid-start, so this was a glitch.
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_DATA: begin
          if (w_cnt_zero) begin
            r_shift <= {r_rxs, r_shift[7:1]};  // LSB arrives first
            r_cnt   <= FULL_M1;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_cnt_zero) begin
            r_par_bit <= r_rxs;
            r_cnt     <= FULL_M1;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (w_cnt_zero) begin
            // The FSM returns to IDLE at mid-stop. This leaves half a bit of
            // margin for a back-to-back start edge.
            if (r_rxs && !w_par_bad) begin
              r_we      <= 1'b1;
              r_wr_data <= r_shift;
            end
            r_frame_err <= ~r_rxs;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_par_bad;
`endif
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
